// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: feeds a bank of JK flip-flops so that their outputs
// step through a queue of target words. Each word is applied for one cycle
// as J/K excitation and then checked against the bank's observed state.
module jk_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter bit XFILL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           j,
  output logic [WIDTH-1:0]           k,
  input  logic [WIDTH-1:0]           q_fb,
  output logic                       busy,
  output logic                       mismatch,
  output logic [7:0]                 err_count,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic             mismatch_q;
  logic [7:0]       err_q;

  logic             push, pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] j_d, k_d;

  // A word may leave the FIFO whenever the FSM is ready to start a new drive;
  // CHECK pops too, which gives back-to-back words one drive every two cycles.
  assign in_ready = rst_n & (count_q < (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = ((state_q == IDLE) || (state_q == CHECK)) && (count_q != '0);
  assign head     = mem_q[rptr_q];

  // Excitation table: a bit at 0 needs J=target, a bit at 1 needs K=~target;
  // the remaining input of each pair is a don't-care and takes the fill value.
  assign fill = {WIDTH{XFILL}};
  assign j_d  = (~q_fb & head) | (q_fb & fill);
  assign k_d  = (q_fb & ~head) | (~q_fb & fill);

  assign j          = j_q;
  assign k          = k_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state selection: any pop starts a drive, DRIVE always moves to CHECK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = DRIVE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = pop ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered J/K drive, captured target and the mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      j_q        <= '0;
      k_q        <= '0;
      target_q   <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= 1'b0;
      if (pop) begin
        j_q      <= j_d;
        k_q      <= k_d;
        target_q <= head;
      end else begin
        j_q <= '0;
        k_q <= '0;
      end
      if ((state_q == CHECK) && (q_fb != target_q)) begin
        mismatch_q <= 1'b1;
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end

endmodule
